// File: rtl/yaklasik_bolme.sv
// Approximate divider: a tag cache keyed on operand upper bits fronts a 32-cycle restoring divider.
// Hits return the stored result of the first request with the same tag.
module yaklasik_bolme #(
  parameter int unsigned SATIR_SAYISI = 8,
  parameter int unsigned ETIKET_BIT   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        basla,
  input  logic [31:0] bolunen,
  input  logic [31:0] bolen,
  output logic        hazir,
  output logic        gecerli,
  output logic [31:0] tahmini_bolum,
  output logic [31:0] tahmini_kalan,
  output logic        bellekten
);

  localparam int unsigned SATIR_W  = (SATIR_SAYISI > 1) ? $clog2(SATIR_SAYISI) : 1;
  localparam int unsigned ETIKET_W = 2 * ETIKET_BIT;

  typedef enum logic [1:0] {BOS, ARA, BOL, YAZ} durum_t;

  durum_t              durum, durum_d;
  logic [31:0]         a_q, a_d, b_q, b_d;
  logic [ETIKET_W-1:0] etiket_q, etiket_d;
  logic [31:0]         r_q, r_d, q_q, q_d;
  logic [4:0]          sayac, sayac_d;
  logic [SATIR_W-1:0]  satir, satir_d;
  logic                hazir_d, gecerli_d, bellekten_d;
  logic [31:0]         bolum_d, kalan_d;
  logic                yaz_en;

  logic [SATIR_SAYISI-1:0] dolu;
  logic [ETIKET_W-1:0]     etiket_m [SATIR_SAYISI];
  logic [31:0]             bolum_m  [SATIR_SAYISI];
  logic [31:0]             kalan_m  [SATIR_SAYISI];

  logic               isabet;
  logic [SATIR_W-1:0] isabet_idx;
  logic [32:0]        r_kay, deneme;

  // Tag lookup; scanning downward lets the lowest matching index win.
  always_comb begin
    isabet     = 1'b0;
    isabet_idx = '0;
    for (int i = int'(SATIR_SAYISI) - 1; i >= 0; i--) begin
      if (dolu[i] && (etiket_m[i] == etiket_q)) begin
        isabet     = 1'b1;
        isabet_idx = SATIR_W'(i);
      end
    end
  end

  // One restoring-division step on the shifted partial remainder.
  always_comb begin
    r_kay  = {r_q, q_q[31]};
    deneme = r_kay - {1'b0, b_q};
  end

  always_comb begin
    durum_d     = durum;
    a_d         = a_q;
    b_d         = b_q;
    etiket_d    = etiket_q;
    r_d         = r_q;
    q_d         = q_q;
    sayac_d     = sayac;
    satir_d     = satir;
    gecerli_d   = 1'b0;
    bellekten_d = bellekten;
    bolum_d     = tahmini_bolum;
    kalan_d     = tahmini_kalan;
    yaz_en      = 1'b0;
    case (durum)
      BOS: begin
        if (basla) begin
          a_d      = bolunen;
          b_d      = bolen;
          etiket_d = {bolunen[31 -: ETIKET_BIT], bolen[31 -: ETIKET_BIT]};
          durum_d  = ARA;
        end
      end
      ARA: begin
        if (isabet) begin
          bolum_d     = bolum_m[isabet_idx];
          kalan_d     = kalan_m[isabet_idx];
          bellekten_d = 1'b1;
          gecerli_d   = 1'b1;
          durum_d     = BOS;
        end else if (b_q == 32'd0) begin
          bolum_d     = 32'hFFFF_FFFF;
          kalan_d     = a_q;
          bellekten_d = 1'b0;
          gecerli_d   = 1'b1;
          durum_d     = BOS;
        end else begin
          r_d     = 32'd0;
          q_d     = a_q;
          sayac_d = 5'd0;
          durum_d = BOL;
        end
      end
      BOL: begin
        if (!deneme[32]) begin
          r_d = deneme[31:0];
          q_d = {q_q[30:0], 1'b1};
        end else begin
          r_d = r_kay[31:0];
          q_d = {q_q[30:0], 1'b0};
        end
        sayac_d = 5'(sayac + 5'd1);
        if (sayac == 5'd31) durum_d = YAZ;
      end
      YAZ: begin
        yaz_en      = 1'b1;
        satir_d     = (satir == SATIR_W'(SATIR_SAYISI - 1)) ? '0 : SATIR_W'(satir + 1'b1);
        bolum_d     = q_q;
        kalan_d     = r_q;
        bellekten_d = 1'b0;
        gecerli_d   = 1'b1;
        durum_d     = BOS;
      end
      default: durum_d = BOS;
    endcase
    hazir_d = (durum_d == BOS);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      durum         <= BOS;
      a_q           <= '0;
      b_q           <= '0;
      etiket_q      <= '0;
      r_q           <= '0;
      q_q           <= '0;
      sayac         <= '0;
      satir         <= '0;
      dolu          <= '0;
      hazir         <= 1'b1;
      gecerli       <= 1'b0;
      bellekten     <= 1'b0;
      tahmini_bolum <= '0;
      tahmini_kalan <= '0;
    end else begin
      durum         <= durum_d;
      a_q           <= a_d;
      b_q           <= b_d;
      etiket_q      <= etiket_d;
      r_q           <= r_d;
      q_q           <= q_d;
      sayac         <= sayac_d;
      satir         <= satir_d;
      hazir         <= hazir_d;
      gecerli       <= gecerli_d;
      bellekten     <= bellekten_d;
      tahmini_bolum <= bolum_d;
      tahmini_kalan <= kalan_d;
      if (yaz_en) dolu[satir] <= 1'b1;
    end
  end

  // Cache payload needs no reset; rows are only trusted through dolu.
  always_ff @(posedge clk) begin
    if (yaz_en) begin
      etiket_m[satir] <= etiket_q;
      bolum_m[satir]  <= q_q;
      kalan_m[satir]  <= r_q;
    end
  end

endmodule

// File: tb/tb_yaklasik_bolme.sv
// Scoreboard bench for yaklasik_bolme: directed requests push expected results,
// a negedge monitor pops and checks every gecerli pulse including its latency.
module tb_yaklasik_bolme;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        basla = 1'b0;
  logic [31:0] bolunen = '0;
  logic [31:0] bolen = '0;
  logic        hazir, gecerli, bellekten;
  logic [31:0] tahmini_bolum, tahmini_kalan;

  yaklasik_bolme dut (
    .clk(clk), .rst_n(rst_n), .basla(basla), .bolunen(bolunen), .bolen(bolen),
    .hazir(hazir), .gecerli(gecerli), .tahmini_bolum(tahmini_bolum),
    .tahmini_kalan(tahmini_kalan), .bellekten(bellekten)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] bolum;
    logic [31:0] kalan;
    logic        mem;
    int          lat;
    int          e0;
  } beklenen_t;

  beklenen_t kuyruk[$];
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  logic onceki_g = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic kontrol(input string ad, input logic [31:0] gercek, input logic [31:0] istenen);
    n_cmp++;
    if (gercek !== istenen) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", ad, gercek, istenen, cyc);
    end
  endtask

  // Monitor: every gecerli pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (gecerli && onceki_g) begin
        n_cmp++; n_bad++;
        $display("FAIL gecerli_width: high on two consecutive cycles at %0d", cyc);
      end
      if (gecerli && !onceki_g) begin
        if (kuyruk.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_gecerli: bolum=0x%08h with nothing outstanding", tahmini_bolum);
        end else begin
          beklenen_t e;
          e = kuyruk.pop_front();
          kontrol("bolum", tahmini_bolum, e.bolum);
          kontrol("kalan", tahmini_kalan, e.kalan);
          kontrol("bellekten", 32'(bellekten), 32'(e.mem));
          kontrol("latency", 32'(cyc - e.e0), 32'(e.lat));
        end
      end
    end
    onceki_g = gecerli;
  end

  task automatic hazir_bekle();
    int w = 0;
    @(negedge clk);
    while (!hazir && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!hazir) begin
      n_cmp++; n_bad++;
      $display("FAIL hazir_timeout: got 0 expected 1");
    end
  endtask

  // Issue one request and return the acceptance cycle index.
  task automatic gonder(input logic [31:0] a, input logic [31:0] b, output int e0);
    hazir_bekle();
    basla = 1'b1; bolunen = a; bolen = b;
    @(posedge clk);
    #1;
    e0 = cyc;
    basla = 1'b0; bolunen = $urandom; bolen = $urandom;
  endtask

  task automatic istek(input logic [31:0] a, input logic [31:0] b, input logic [31:0] eb,
                       input logic [31:0] ek, input logic em, input int lat);
    beklenen_t e;
    int e0;
    gonder(a, b, e0);
    e.bolum = eb; e.kalan = ek; e.mem = em; e.lat = lat; e.e0 = e0;
    kuyruk.push_back(e);
  endtask

  task automatic bosalt();
    int w = 0;
    while (kuyruk.size() != 0 && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (kuyruk.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", kuyruk.size());
      kuyruk.delete();
    end
  endtask

  task automatic sifirla();
    basla = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    kontrol("rst_hazir", 32'(hazir), 32'd1);
    kontrol("rst_gecerli", 32'(gecerli), 32'd0);
    kontrol("rst_bolum", tahmini_bolum, 32'd0);
    kontrol("rst_kalan", tahmini_kalan, 32'd0);
    kontrol("rst_bellekten", 32'(bellekten), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int e0;
    sifirla();

    // Miss, then hits on the same tag (approximate answer for 50/3).
    istek(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34);
    istek(32'd100, 32'd7, 32'd14, 32'd2, 1'b1, 1);
    istek(32'd50,  32'd3, 32'd14, 32'd2, 1'b1, 1);
    // Divide by zero: fast path, never cached.
    istek(32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1);
    istek(32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1);
    bosalt();

    // Reset mid-division at counter=10: no result, state cleared.
    gonder(32'h5000_0000, 32'd3, e0);
    repeat (11) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    kontrol("abort_hazir", 32'(hazir), 32'd1);
    kontrol("abort_bolum", tahmini_bolum, 32'd0);
    kontrol("abort_kalan", tahmini_kalan, 32'd0);
    kontrol("abort_bellekten", 32'(bellekten), 32'd0);
    // Cache was invalidated, so the earlier hit now misses.
    istek(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34);
    bosalt();

    // basla held with other operands during the division is ignored.
    istek(32'h2000_0000, 32'h1000_0000, 32'd2, 32'd0, 1'b0, 34);
    repeat (3) @(negedge clk);
    basla = 1'b1; bolunen = 32'd5; bolen = 32'd1;
    repeat (10) @(negedge clk);
    basla = 1'b0;
    bosalt();
    istek(32'hFFFF_FFFF, 32'h0001_0000, 32'h0000_FFFF, 32'h0000_FFFF, 1'b0, 34);
    bosalt();

    // Row pointer wrap: zero-divides must not advance it.
    sifirla();
    istek(32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1);
    istek(32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1);
    for (int n = 1; n <= 9; n++)
      istek((32'(n) << 28) + 32'd100, (32'(n) << 28) + 32'd7, 32'd1, 32'd93, 1'b0, 34);
    istek(32'h1000_0064, 32'h1000_0007, 32'd1, 32'd93, 1'b0, 34);
    istek(32'h3000_0064, 32'h3000_0007, 32'd1, 32'd93, 1'b1, 1);
    istek(32'h2000_0064, 32'h2000_0007, 32'd1, 32'd93, 1'b0, 34);
    bosalt();

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/yaklasik_bolme.md
YAKLASIK_BOLME -- requirements
Module: yaklasik_bolme

Interface
REQ-001 SATIR_SAYISI, default 8, number of result-cache rows; the row pointer wraps at SATIR_SAYISI-1.
REQ-002 ETIKET_BIT, default 4, number of upper bits taken from each operand to form the cache tag.
REQ-003 clk  input  1  single clock for the block; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 basla  input  1  start request; sampled only while hazir=1.
REQ-006 bolunen  input  32  unsigned dividend.
REQ-007 bolen  input  32  unsigned divisor.
REQ-008 hazir  output  1  block is idle and accepts basla.
REQ-009 gecerli  output  1  one-cycle pulse marking a new result.
REQ-010 tahmini_bolum  output  32  registered quotient (exact or cached).
REQ-011 tahmini_kalan  output  32  registered remainder (exact or cached).
REQ-012 bellekten  output  1  registered flag; 1 = last result came from the cache.

Function
REQ-013 The block SHALL use four states: BOS (idle), ARA (lookup), BOL (divide) and YAZ (store/output); hazir SHALL be 1 exactly when the state is BOS.
REQ-014 Acceptance (edge E0): on a rising edge with basla=1 in BOS, the block SHALL capture bolunen, bolen and tag={bolunen[31:28], bolen[31:28]}, then enter ARA; later input changes SHALL be ignored.
REQ-015 basla while not in BOS SHALL be ignored, with no queuing.
REQ-016 Cache: SATIR_SAYISI rows, each holding valid, an 8-bit tag, a 32-bit quotient and a 32-bit remainder; only valid rows SHALL match, and on multiple matches the lowest index wins.
REQ-017 ARA hit (edge E0+1): the block SHALL load the row's quotient/remainder into the outputs, set bellekten=1, pulse gecerli and return to BOS; the cache SHALL NOT change.
REQ-018 ARA miss with captured bolen=0 (edge E0+1): outputs SHALL be 0xFFFF_FFFF and the captured bolunen, bellekten=0, gecerli pulses, the state returns to BOS, and there SHALL be no cache write.
REQ-019 ARA miss with bolen≠0: the block SHALL enter BOL with a 5-bit counter cleared to 0.
REQ-020 BOL SHALL perform restoring division, one quotient bit per edge, MSB first: shift {R,Q} left by one, do a 33-bit trial R-bolen, and if the result is nonnegative set R=trial and Q[0]=1.
REQ-021 BOL SHALL take 32 edges (E0+2..E0+33); on the edge where the counter is 31 the block SHALL enter YAZ.
REQ-022 YAZ (edge E0+34): the block SHALL write {valid=1, tag, Q, R} to row satir, advance satir (SATIR_SAYISI-1 -> 0), load the outputs with Q/R, set bellekten=0, pulse gecerli and return to BOS.
REQ-023 Hits return the stored result of the first request with the same tag; this approximation is intended.
REQ-024 gecerli SHALL be high for exactly one cycle per accepted request; outputs SHALL hold their values until the next result.
REQ-025 The earliest next acceptance SHALL be the edge after gecerli rises.

Reset
REQ-026 rst_n=0 SHALL immediately force: state BOS, all valid bits 0, satir=0, counter=0, tahmini_bolum=0, tahmini_kalan=0, gecerli=0, bellekten=0.
REQ-027 Reset during BOL or YAZ SHALL abandon the operation with no gecerli pulse and no partial cache write.
REQ-028 After release, the first acceptance is possible on the first rising edge with rst_n=1.

Verification
REQ-029 Reset, then 100/7 -> miss; gecerli at E0+34, bolum=14, kalan=2, bellekten=0, row 0 written.
REQ-030 Then 100/7 again -> gecerli at E0+1, 14/2, bellekten=1; then 50/3 (same tag 0x00) -> hit, returns 14/2.
REQ-031 0x8000_0000/0 -> gecerli at E0+1, bolum=0xFFFF_FFFF, kalan=0x8000_0000; repeated request takes the same path and satir stays unchanged.
REQ-032 Nine misses with distinct tags 0x11..0x99 -> the ninth overwrites row 0; a repeat of the tag-0x11 request then misses (latency 34).
REQ-033 rst_n pulsed low during BOL at counter=10 -> no gecerli, outputs=0, hazir=1, all rows invalid.
REQ-034 basla held high during BOL with different operands -> ignored; the result matches the originally captured operands.
